// File: rtl/ddr3_mem_bram.sv
// Block-RAM memory target speaking the ddr3_axi_ctrl mem_* burst handshake.
// Optional: define DDR3_MEM_BRAM_RANGE_CHECK_EN to fault and isolate out-of-range addresses.
module ddr3_mem_bram #(
  parameter int WIDTH = 32,
  parameter int MASKS = WIDTH / 8,
  parameter int ADDRS = 32,
  parameter int REQID = 4,
  parameter int MBITS = 10,
  parameter int BURST = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mem_store_i,
  input  logic             mem_fetch_i,
  output logic             mem_accept_o,
  output logic             mem_error_o,
  input  logic [REQID-1:0] mem_req_id_i,
  input  logic [ADDRS-1:0] mem_addr_i,
  input  logic             mem_valid_i,
  output logic             mem_ready_o,
  input  logic             mem_last_i,
  input  logic [MASKS-1:0] mem_wrmask_i,
  input  logic [WIDTH-1:0] mem_wrdata_i,
  output logic             mem_valid_o,
  input  logic             mem_ready_i,
  output logic             mem_last_o,
  output logic [REQID-1:0] mem_resp_id_o,
  output logic [WIDTH-1:0] mem_rddata_o
);

  localparam int OFS   = $clog2(MASKS);
  localparam int DEPTH = 1 << MBITS;
  localparam int CBITS = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t           state_reg;
  logic             accept_reg;
  logic             error_reg;
  logic             wready_reg;
  logic             zero_reg;
  logic [MBITS-1:0] waddr_reg;
  logic [MBITS-1:0] raddr_reg;
  logic [CBITS-1:0] wcnt_reg;
  logic [CBITS-1:0] icnt_reg;
  logic [REQID-1:0] resp_id_reg;

  // RAM read register and the two-entry output skid buffer behind it
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q_reg;
  logic             ram_vld_reg;
  logic             ram_last_reg;
  logic [1:0]       fill_reg;
  logic [WIDTH-1:0] q0_data_reg;
  logic [WIDTH-1:0] q1_data_reg;
  logic             q0_last_reg;
  logic             q1_last_reg;

  logic [MBITS-1:0] req_word;
  logic             misaligned;
  logic             out_of_range;
  logic             take;
  logic             take_fetch;
  logic             wr_beat;
  logic             wr_final_beat;
  logic             out_valid;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic [2:0]       occupancy;
  logic             room;
  logic             rd_more;
  logic             rd_issue;
  logic             rd_last;
  logic [MBITS-1:0] rd_addr;
  logic [MASKS-1:0] lane_we;

  assign req_word = mem_addr_i[OFS +: MBITS];

  if (OFS > 0) begin : g_lsb
    assign misaligned = |mem_addr_i[OFS-1:0];
  end else begin : g_no_lsb
    assign misaligned = 1'b0;
  end

`ifdef DDR3_MEM_BRAM_RANGE_CHECK_EN
  assign out_of_range = |(mem_addr_i >> (OFS + MBITS));
`else
  logic unused_upper_addr;
  assign unused_upper_addr = |(mem_addr_i >> (OFS + MBITS));
  assign out_of_range      = 1'b0;
`endif

  // Store wins over a simultaneous fetch; the fetch must be presented again
  assign take       = accept_reg && (mem_store_i || mem_fetch_i);
  assign take_fetch = take && !mem_store_i && mem_fetch_i;

  assign wr_beat       = (state_reg == WRITE) && wready_reg && mem_valid_i;
  assign wr_final_beat = (wcnt_reg == CBITS'(BURST - 1));

  assign out_valid = (fill_reg != 2'd0);
  assign pop       = out_valid && mem_ready_i;
  assign push      = ram_vld_reg;
  assign push_data = zero_reg ? '0 : ram_q_reg;

  // Issue another read only if it is guaranteed a skid slot when it lands
  assign occupancy = {1'b0, fill_reg} + {2'b00, ram_vld_reg};
  assign room      = occupancy <= (3'd1 + {2'b00, pop});
  assign rd_more   = (state_reg == READ) && (icnt_reg < CBITS'(BURST)) && room;

  // The first beat is read in the accept cycle straight off the request address
  assign rd_issue = take_fetch || rd_more;
  assign rd_addr  = (state_reg == READ) ? raddr_reg : req_word;
  assign rd_last  = (state_reg == READ) && (icnt_reg == CBITS'(BURST - 1));

  for (genvar gi = 0; gi < MASKS; gi++) begin : g_lane
    assign lane_we[gi] = !reset && wr_beat && !zero_reg && mem_wrmask_i[gi];
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < MASKS; i++) begin
      if (lane_we[i]) begin
        mem[waddr_reg][i*8 +: 8] <= mem_wrdata_i[i*8 +: 8];
      end
    end
    if (rd_issue) begin
      ram_q_reg <= mem[rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      accept_reg   <= 1'b0;
      error_reg    <= 1'b0;
      wready_reg   <= 1'b0;
      zero_reg     <= 1'b0;
      waddr_reg    <= '0;
      raddr_reg    <= '0;
      wcnt_reg     <= '0;
      icnt_reg     <= '0;
      resp_id_reg  <= '0;
      ram_vld_reg  <= 1'b0;
      ram_last_reg <= 1'b0;
      fill_reg     <= 2'd0;
      q0_data_reg  <= '0;
      q1_data_reg  <= '0;
      q0_last_reg  <= 1'b0;
      q1_last_reg  <= 1'b0;
    end else begin
      error_reg    <= 1'b0;
      ram_vld_reg  <= rd_issue;
      ram_last_reg <= rd_last;

      unique case (state_reg)
        IDLE: begin
          accept_reg <= 1'b1;
          if (take) begin
            accept_reg <= 1'b0;
            error_reg  <= misaligned || out_of_range;
            zero_reg   <= out_of_range;
            if (mem_store_i) begin
              state_reg  <= WRITE;
              wready_reg <= 1'b1;
              waddr_reg  <= req_word;
              wcnt_reg   <= '0;
            end else begin
              state_reg   <= READ;
              resp_id_reg <= mem_req_id_i;
              raddr_reg   <= req_word + 1'b1;
              icnt_reg    <= CBITS'(1);
            end
          end
        end
        WRITE: begin
          if (wr_beat) begin
            waddr_reg <= waddr_reg + 1'b1;
            wcnt_reg  <= wcnt_reg + 1'b1;
            // Flags both an early last and a full burst that never saw last
            if (mem_last_i != wr_final_beat) begin
              error_reg <= 1'b1;
            end
            if (mem_last_i || wr_final_beat) begin
              state_reg  <= IDLE;
              wready_reg <= 1'b0;
              accept_reg <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_more) begin
            raddr_reg <= raddr_reg + 1'b1;
            icnt_reg  <= icnt_reg + 1'b1;
          end
          if (pop && q0_last_reg) begin
            state_reg  <= IDLE;
            accept_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      unique case ({push, pop})
        2'b10: begin
          if (fill_reg == 2'd0) begin
            q0_data_reg <= push_data;
            q0_last_reg <= ram_last_reg;
          end else begin
            q1_data_reg <= push_data;
            q1_last_reg <= ram_last_reg;
          end
          fill_reg <= fill_reg + 2'd1;
        end
        2'b01: begin
          q0_data_reg <= q1_data_reg;
          q0_last_reg <= q1_last_reg;
          fill_reg    <= fill_reg - 2'd1;
        end
        2'b11: begin
          if (fill_reg == 2'd1) begin
            q0_data_reg <= push_data;
            q0_last_reg <= ram_last_reg;
          end else begin
            q0_data_reg <= q1_data_reg;
            q0_last_reg <= q1_last_reg;
            q1_data_reg <= push_data;
            q1_last_reg <= ram_last_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_accept_o  = accept_reg;
  assign mem_error_o   = error_reg;
  assign mem_ready_o   = wready_reg;
  assign mem_valid_o   = out_valid;
  assign mem_last_o    = out_valid && q0_last_reg;
  assign mem_resp_id_o = resp_id_reg;
  assign mem_rddata_o  = q0_data_reg;

endmodule

// File: tb/tb_ddr3_mem_bram.sv
// Scoreboard bench for ddr3_mem_bram: directed bursts, read beats checked by a separate monitor.
module tb_ddr3_mem_bram;

  logic        clock;
  logic        reset;
  logic        mem_store_i;
  logic        mem_fetch_i;
  logic        mem_accept_o;
  logic        mem_error_o;
  logic [3:0]  mem_req_id_i;
  logic [31:0] mem_addr_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic        mem_last_i;
  logic [3:0]  mem_wrmask_i;
  logic [31:0] mem_wrdata_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_last_o;
  logic [3:0]  mem_resp_id_o;
  logic [31:0] mem_rddata_o;

  ddr3_mem_bram dut (
    .clock(clock), .reset(reset),
    .mem_store_i(mem_store_i), .mem_fetch_i(mem_fetch_i),
    .mem_accept_o(mem_accept_o), .mem_error_o(mem_error_o),
    .mem_req_id_i(mem_req_id_i), .mem_addr_i(mem_addr_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_last_i(mem_last_i),
    .mem_wrmask_i(mem_wrmask_i), .mem_wrdata_i(mem_wrdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_last_o(mem_last_o),
    .mem_resp_id_o(mem_resp_id_o), .mem_rddata_o(mem_rddata_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       e;
  int          vectors = 0;
  int          miscompares = 0;
  int          err_seen = 0;
  int          cyc = 0;
  int          first_hs = 0;
  int          last_hs = 0;
  int          hs_idx = 0;
  logic        stall_prev = 1'b0;
  logic [36:0] prev_out = '0;
  logic [31:0] wdat[4];
  logic [3:0]  wmsk[4];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every read handshake, counts error pulses
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
      hs_idx     = 0;
    end else begin
      if (mem_error_o) err_seen++;
      if (mem_valid_o && stall_prev)
        check("rd_stable", {mem_last_o, mem_resp_id_o, mem_rddata_o}, prev_out);
      if (mem_valid_o && mem_ready_i) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected_beat", mem_valid_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rd_beat", {mem_last_o, mem_resp_id_o, mem_rddata_o}, {e.last, e.id, e.data});
          $display("read beat: data %08h id %0h last %0b", mem_rddata_o, mem_resp_id_o, mem_last_o);
          if (hs_idx == 0) first_hs = cyc;
          if (e.last) begin
            last_hs = cyc;
            hs_idx  = 0;
          end else begin
            hs_idx++;
          end
        end
      end
      stall_prev = mem_valid_o && !mem_ready_i;
      prev_out   = {mem_last_o, mem_resp_id_o, mem_rddata_o};
    end
  end

  task automatic wait_accept();
    int n = 0;
    while (!mem_accept_o && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("accept_wait", mem_accept_o, 1'b1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic with_fetch,
                          input int nbeats, input int last_at, input int exp_err);
    int es;
    wait_accept();
    es = err_seen;
    mem_store_i = 1'b1; mem_fetch_i = with_fetch; mem_addr_i = addr; mem_req_id_i = 4'hE;
    @(posedge clock); #1;
    mem_store_i = 1'b0; mem_fetch_i = 1'b0;
    check("store_accept_drop", mem_accept_o, 1'b0);
    for (int b = 0; b < nbeats; b++) begin
      check("store_ready", mem_ready_o, 1'b1);
      mem_valid_i = 1'b1; mem_wrdata_i = wdat[b]; mem_wrmask_i = wmsk[b];
      mem_last_i = (b == last_at);
      @(posedge clock); #1;
      if (b < nbeats - 1) check("store_accept_low", mem_accept_o, 1'b0);
    end
    mem_valid_i = 1'b0; mem_last_i = 1'b0;
    check("store_ready_end", mem_ready_o, 1'b0);
    check("store_accept_back", mem_accept_o, 1'b1);
    @(posedge clock); #1;
    check("store_no_read", mem_valid_o, 1'b0);
    check("store_err", err_seen - es, exp_err);
    $display("store addr %08h beats %0d errors %0d", addr, nbeats, err_seen - es);
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [3:0] id, input logic toggle,
                          input int exp_err, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
    int a, n, es;
    logic [31:0] ev[4];
    ev = '{e0, e1, e2, e3};
    wait_accept();
    es = err_seen;
    for (int b = 0; b < 4; b++) exp_q.push_back('{data: ev[b], id: id, last: (b == 3)});
    mem_fetch_i = 1'b1; mem_addr_i = addr; mem_req_id_i = id; mem_ready_i = 1'b1;
    a = cyc;
    @(posedge clock); #1;
    mem_fetch_i = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || !mem_accept_o) && n < 100) begin
      if (toggle) mem_ready_i = ~mem_ready_i;
      @(posedge clock); #1;
      n++;
    end
    mem_ready_i = 1'b1;
    check("fetch_done", n < 100, 1'b1);
    check("fetch_err", err_seen - es, exp_err);
    if (!toggle) begin
      check("fetch_first_latency", first_hs - a, 2);
      check("fetch_back_to_back", last_hs - first_hs, 3);
    end
    $display("fetch addr %08h id %0h cycles %0d errors %0d", addr, id, n, err_seen - es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_store_i = 1'b0; mem_fetch_i = 1'b0; mem_req_id_i = '0; mem_addr_i = '0;
    mem_valid_i = 1'b0; mem_last_i = 1'b0; mem_wrmask_i = '0; mem_wrdata_i = '0; mem_ready_i = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {mem_accept_o, mem_error_o, mem_ready_o, mem_valid_o, mem_last_o}, 5'b0);
    reset = 1'b0;
    check("accept_after_reset_0", mem_accept_o, 1'b0);
    @(posedge clock); #1;
    check("accept_after_reset_1", mem_accept_o, 1'b1);

    // Basic full burst and read-back with ready held high
    wdat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}; wmsk = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_store(32'h0, 1'b0, 4, 3, 0);
    do_fetch(32'h0, 4'h5, 1'b0, 0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

    // Byte lanes, read back through a toggling ready
    wdat = '{32'hAABBCCDD, 32'h0, 32'h0, 32'h0};
    do_store(32'h10, 1'b0, 4, 3, 0);
    wdat = '{32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}; wmsk = '{4'h5, 4'h0, 4'h0, 4'h0};
    do_store(32'h10, 1'b0, 4, 3, 0);
    do_fetch(32'h10, 4'h3, 1'b1, 0, 32'hAA22CC44, 32'h0, 32'h0, 32'h0);

    // Top-of-RAM wrap
    wdat = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3}; wmsk = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_store(32'hFFC, 1'b0, 4, 3, 0);
    do_fetch(32'hFFC, 4'h9, 1'b0, 0, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3);
    do_fetch(32'h0, 4'h1, 1'b0, 0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'h44444444);

    // Misaligned addresses fault but still operate on the word
    wdat = '{32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3};
    do_store(32'h2, 1'b0, 4, 3, 1);
    do_fetch(32'h3, 4'h2, 1'b0, 1, 32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3);

    // Store and fetch together: store wins, fetch needs re-presenting
    wdat = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
    do_store(32'h20, 1'b1, 4, 3, 0);
    do_fetch(32'h20, 4'hA, 1'b0, 0, 32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3);

    // Early last, then a burst that never raises last
    wdat = '{32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3};
    do_store(32'h40, 1'b0, 2, 1, 1);
    do_store(32'h80, 1'b0, 4, -1, 1);
    do_fetch(32'h80, 4'hB, 1'b1, 0, 32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3);

`ifdef DDR3_MEM_BRAM_RANGE_CHECK_EN
    wdat = '{32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE};
    do_store(32'h1000, 1'b0, 4, 3, 1);
    do_fetch(32'h1000, 4'h6, 1'b0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    do_fetch(32'h0, 4'h7, 1'b0, 0, 32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3);
`endif

    // Reset while the second read beat is on the bus
    wait_accept();
    exp_q.push_back('{data: 32'hB0B0B0B0, id: 4'h4, last: 1'b0});
    mem_fetch_i = 1'b1; mem_addr_i = 32'h0; mem_req_id_i = 4'h4; mem_ready_i = 1'b1;
    @(posedge clock); #1;
    mem_fetch_i = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst_mid_valid_before", mem_valid_o, 1'b1);
    reset = 1'b1; mem_ready_i = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_outputs", {mem_valid_o, mem_last_o, mem_accept_o}, 3'b000);
    check("rst_mid_consumed", exp_q.size(), 0);
    $display("reset mid-read: valid %0b last %0b accept %0b", mem_valid_o, mem_last_o, mem_accept_o);
    reset = 1'b0; mem_ready_i = 1'b1;
    do_fetch(32'h0, 4'h8, 1'b0, 0, 32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3);

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
